// File: rtl/ap_ctrl_pkg.sv
// ap_ctrl_pkg
// Shared definitions for the ap_ctrl_chain driver:
//   - default widths for the transaction/start/done counters and the
//     cycle timestamp / latency values
//   - default limit on started-but-not-done transactions
//   - the control FSM state type
package ap_ctrl_pkg;

  localparam int CNT_W_DEF     = 16;
  localparam int LAT_W_DEF     = 32;
  localparam int MAX_OUTST_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/ap_ts_fifo.sv
// ap_ts_fifo
// Timestamp FIFO holding the launch cycle of every outstanding transaction.
// First-word-fall-through: pop_data always shows the oldest entry.
// A push and a pop may happen in the same cycle, including when full.
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous active-low reset (empties the FIFO)
//   push       write push_data (ignored when full unless popping too)
//   push_data  WIDTH-bit entry to store
//   pop        drop the oldest entry (ignored when empty)
//   pop_data   oldest entry
//   full       DEPTH entries held
//   empty      no entries held
module ap_ts_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  // A depth-1 FIFO still needs a 1-bit pointer to index the storage.
  localparam int              AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0]   LAST    = AW'(DEPTH - 1);
  localparam logic [AW:0]     DEPTH_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == DEPTH_C);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ap_ctrl_chain_driver.sv
// ap_ctrl_chain_driver
// Drives an HLS-style ap_ctrl_chain block: launches a commanded number of
// transactions with ap_start/ap_ready, acknowledges completions with
// ap_done/ap_continue (with a programmable gap), keeps up to MAX_OUTST
// transactions in flight and measures per-transaction latency.
// Ports:
//   clock, reset          rising-edge clock, async active-low reset
//   cmd_valid/cmd_ready   run request handshake (ready only in IDLE)
//   cmd_num_txn           transactions to launch (0 = immediate finish)
//   cmd_cont_gap          ap_continue low cycles after each accepted done
//   ap_start/ap_ready     launch handshake to the driven block
//   ap_done/ap_continue   completion handshake from the driven block
//   busy                  not IDLE
//   finish                one-cycle pulse at run completion
//   started_cnt/done_cnt  accepted starts / accepted (matched) dones
//   last_lat/max_lat      latest and largest latency of the run, in cycles
//   err_done              sticky: a done arrived with nothing outstanding
module ap_ctrl_chain_driver
  import ap_ctrl_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int LAT_W     = LAT_W_DEF,
  parameter int MAX_OUTST = MAX_OUTST_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_num_txn,
  input  logic [3:0]       cmd_cont_gap,
  output logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  output logic             ap_continue,
  output logic             busy,
  output logic             finish,
  output logic [CNT_W-1:0] started_cnt,
  output logic [CNT_W-1:0] done_cnt,
  output logic [LAT_W-1:0] last_lat,
  output logic [LAT_W-1:0] max_lat,
  output logic             err_done
);

  localparam logic [CNT_W-1:0] OUTST_LIM = CNT_W'(MAX_OUTST);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] num_q;
  logic [CNT_W-1:0] num_eff;
  logic [CNT_W-1:0] started_nxt;
  logic [CNT_W-1:0] done_nxt;
  logic [CNT_W-1:0] outst_nxt;
  logic [3:0]       gap_q;
  logic [3:0]       gap_cnt;
  logic [LAT_W-1:0] now;
  logic [LAT_W-1:0] ts_head;
  logic [LAT_W-1:0] lat_now;
  logic             cmd_acc;
  logic             st_acc;
  logic             dn_acc;
  logic             dn_ok;
  logic             dn_err;
  logic             start_nxt;
  logic             fifo_push;
  logic             fifo_full;
  logic             fifo_empty;

  function automatic logic [LAT_W-1:0] lat_max(input logic [LAT_W-1:0] a,
                                                input logic [LAT_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  assign cmd_ready   = (state == IDLE);
  assign busy        = (state != IDLE);
  assign finish      = (state == FINISH);
  assign ap_continue = (gap_cnt == 4'd0);

  assign cmd_acc = cmd_valid && cmd_ready;
  assign st_acc  = ap_start && ap_ready;
  assign dn_acc  = ap_done && ap_continue;
  // A done with an empty FIFO has no launch to match: flag it, count nothing.
  assign dn_ok   = dn_acc && !fifo_empty;
  assign dn_err  = dn_acc && fifo_empty;

  assign fifo_push = st_acc && (!fifo_full || dn_ok);
  // Modulo-2^LAT_W difference stays correct across timestamp wrap.
  assign lat_now   = now - ts_head;

  ap_ts_fifo #(
    .DEPTH (MAX_OUTST),
    .WIDTH (LAT_W)
  ) u_ts_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (now),
    .pop       (dn_ok),
    .pop_data  (ts_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    // On command acceptance the new count applies to this cycle's decision.
    num_eff     = cmd_acc ? cmd_num_txn : num_q;
    started_nxt = cmd_acc ? '0 : started_cnt + CNT_W'(st_acc);
    done_nxt    = cmd_acc ? '0 : done_cnt + CNT_W'(dn_ok);
    outst_nxt   = started_nxt - done_nxt;
    state_nxt   = state;

    case (state)
      IDLE:    if (cmd_acc) state_nxt = (cmd_num_txn == '0) ? FINISH : ISSUE;
      ISSUE:   if (st_acc && (started_nxt == num_q)) state_nxt = DRAIN;
      DRAIN:   if (done_cnt == num_q) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // A pending request is held until taken; a new one (including the
    // back-to-back follow-up) only while starts remain and a slot is free.
    start_nxt = (ap_start && !ap_ready) ||
                ((state_nxt == ISSUE) && (started_nxt < num_eff) &&
                 (outst_nxt < OUTST_LIM));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ap_start    <= 1'b0;
      started_cnt <= '0;
      done_cnt    <= '0;
      num_q       <= '0;
      gap_q       <= '0;
      gap_cnt     <= '0;
      now         <= '0;
      last_lat    <= '0;
      max_lat     <= '0;
      err_done    <= 1'b0;
    end else begin
      ap_start    <= start_nxt;
      started_cnt <= started_nxt;
      done_cnt    <= done_nxt;
      now         <= now + 1'b1;

      if (cmd_acc) begin
        num_q   <= cmd_num_txn;
        gap_q   <= cmd_cont_gap;
        max_lat <= '0;
      end

      if (dn_acc)               gap_cnt <= gap_q;
      else if (gap_cnt != 4'd0) gap_cnt <= gap_cnt - 1'b1;

      if (dn_ok) begin
        last_lat <= lat_now;
        max_lat  <= lat_max(max_lat, lat_now);
      end

      if (cmd_acc) err_done <= 1'b0;
      if (dn_err)  err_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ap_ctrl_chain_driver.sv
// tb_ap_ctrl_chain_driver
// Bench for ap_ctrl_chain_driver: a responder plays the driven block
// (ap_ready after a set or random wait, ap_done a set or random number of
// cycles after each launch, in order), and a transaction-level reference
// keeps launch times in a queue to predict counts, latencies, the
// ap_continue gap and the error flag.
module tb_ap_ctrl_chain_driver;
  import ap_ctrl_pkg::*;

  localparam int CNT_W     = CNT_W_DEF;
  localparam int LAT_W     = LAT_W_DEF;
  localparam int MAX_OUTST = MAX_OUTST_DEF;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_num_txn = '0;
  logic [3:0]       cmd_cont_gap = '0;
  logic             ap_start;
  logic             ap_ready = 1'b0;
  logic             ap_done = 1'b0;
  logic             ap_continue;
  logic             busy;
  logic             finish;
  logic [CNT_W-1:0] started_cnt;
  logic [CNT_W-1:0] done_cnt;
  logic [LAT_W-1:0] last_lat;
  logic [LAT_W-1:0] max_lat;
  logic             err_done;

  ap_ctrl_chain_driver #(
    .CNT_W     (CNT_W),
    .LAT_W     (LAT_W),
    .MAX_OUTST (MAX_OUTST)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_num_txn  (cmd_num_txn),
    .cmd_cont_gap (cmd_cont_gap),
    .ap_start     (ap_start),
    .ap_ready     (ap_ready),
    .ap_done      (ap_done),
    .ap_continue  (ap_continue),
    .busy         (busy),
    .finish       (finish),
    .started_cnt  (started_cnt),
    .done_cnt     (done_cnt),
    .last_lat     (last_lat),
    .max_lat      (max_lat),
    .err_done     (err_done)
  );

  always #5 clock = ~clock;

  typedef struct {
    int num;
    int gap;
    int rd;
    int dd;
    int exp_started;
    int exp_done;
    int exp_last;
    int exp_max;
    int exp_stall;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state.
  int now_c = 0;
  int ts_q[$];
  int exp_started, exp_done, exp_last, exp_max, exp_err;
  int cur_gap, gap_left;

  // Responder state.
  int rdy_dly = 0;
  int done_dly = 1;
  int pend_due[$];
  int waited = 0;
  bit inj_done = 1'b0;

  int finish_seen = 0;
  int start_seen  = 0;
  int stall_seen  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic reset_model();
    ts_q.delete();
    pend_due.delete();
    exp_started = 0;
    exp_done    = 0;
    exp_last    = 0;
    exp_max     = 0;
    exp_err     = 0;
    cur_gap     = 0;
    gap_left    = 0;
    waited      = 0;
  endtask

  task automatic drive();
    bit rdy;
    if (rdy_dly < 0) rdy = ($urandom_range(0, 2) != 0);
    else             rdy = (waited >= rdy_dly);
    ap_ready = ap_start && rdy;
    ap_done  = inj_done || (pend_due.size() > 0 && pend_due[0] <= now_c);
  endtask

  task automatic tick();
    bit s_acc, d_acc, c_acc, hold;
    int dd, lat;
    s_acc = ap_start && ap_ready;
    d_acc = ap_done && ap_continue;
    c_acc = cmd_valid && cmd_ready;
    hold  = ap_start && !ap_ready;

    if (ap_start)
      check("start_only_below_max_outst", int'(exp_started - exp_done < MAX_OUTST), 1);
    if (!ap_start && (exp_started - exp_done == MAX_OUTST)) stall_seen = 1;
    if (finish)   finish_seen++;
    if (ap_start) start_seen++;

    if (c_acc) begin
      exp_started = 0;
      exp_done    = 0;
      exp_max     = 0;
      exp_err     = 0;
    end
    if (d_acc) begin
      if (ts_q.size() == 0) exp_err = 1;
      else begin
        lat = now_c - ts_q.pop_front();
        exp_last = lat;
        if (lat > exp_max) exp_max = lat;
        exp_done++;
      end
      if (pend_due.size() > 0 && pend_due[0] <= now_c) void'(pend_due.pop_front());
      gap_left = cur_gap;
    end else if (gap_left > 0) begin
      gap_left--;
    end
    if (c_acc) cur_gap = int'(cmd_cont_gap);
    if (s_acc) begin
      ts_q.push_back(now_c);
      exp_started++;
      dd = (done_dly < 0) ? int'($urandom_range(1, 12)) : done_dly;
      pend_due.push_back(now_c + dd);
    end
    waited   = s_acc ? 0 : (ap_start ? waited + 1 : 0);
    inj_done = 1'b0;

    @(posedge clock);
    now_c++;
    #1;
    check("started_cnt", int'(started_cnt), exp_started);
    check("done_cnt", int'(done_cnt), exp_done);
    check("last_lat", int'(last_lat), exp_last);
    check("max_lat", int'(max_lat), exp_max);
    check("err_done", int'(err_done), exp_err);
    check("ap_continue_gap", int'(ap_continue), int'(gap_left == 0));
    if (hold) check("ap_start_not_withdrawn", int'(ap_start), 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive();
      tick();
    end
  endtask

  task automatic issue_cmd(input int num, input int gap, input int rd, input int dd);
    check("cmd_ready_before_cmd", int'(cmd_ready), 1);
    rdy_dly      = rd;
    done_dly     = dd;
    finish_seen  = 0;
    start_seen   = 0;
    stall_seen   = 0;
    cmd_valid    = 1'b1;
    cmd_num_txn  = CNT_W'(num);
    cmd_cont_gap = 4'(gap);
    drive();
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_finish(input int budget);
    int k;
    k = 0;
    while (!(finish_seen > 0 && cmd_ready) && k < budget) begin
      drive();
      tick();
      k++;
    end
    check("run_completes_in_budget", int'(k < budget), 1);
    check("finish_pulse_cycles", finish_seen, 1);
    check("cmd_ready_after_run", int'(cmd_ready), 1);
    check("busy_after_run", int'(busy), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[4];
    int   num, gap, dc;
    vt[0] = '{3, 0, 1, 5, 3, 3, 5, 5, 0};
    vt[1] = '{8, 0, 0, 20, 8, 8, 20, 20, 1};
    vt[2] = '{4, 3, 0, 1, 4, 4, 10, 10, 0};
    vt[3] = '{3, 0, 0, 1, 3, 3, 1, 1, 0};

    reset_model();
    repeat (3) @(posedge clock);
    #1;
    check("rst_cmd_ready", int'(cmd_ready), 1);
    check("rst_ap_start", int'(ap_start), 0);
    check("rst_ap_continue", int'(ap_continue), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_finish", int'(finish), 0);
    check("rst_started_cnt", int'(started_cnt), 0);
    check("rst_done_cnt", int'(done_cnt), 0);
    check("rst_last_lat", int'(last_lat), 0);
    check("rst_max_lat", int'(max_lat), 0);
    check("rst_err_done", int'(err_done), 0);
    reset = 1'b1;
    idle(2);

    // Directed runs with fixed responder timing.
    for (int i = 0; i < 4; i++) begin
      issue_cmd(vt[i].num, vt[i].gap, vt[i].rd, vt[i].dd);
      wait_finish(500);
      check("vec_started_cnt", int'(started_cnt), vt[i].exp_started);
      check("vec_done_cnt", int'(done_cnt), vt[i].exp_done);
      check("vec_last_lat", int'(last_lat), vt[i].exp_last);
      check("vec_max_lat", int'(max_lat), vt[i].exp_max);
      check("vec_stall_at_max_outst", stall_seen, vt[i].exp_stall);
      check("vec_err_done", int'(err_done), 0);
      idle(2);
    end

    // Zero-length run: straight to FINISH, no launch.
    issue_cmd(0, 0, 0, 1);
    check("zero_finish_next_cycle", int'(finish), 1);
    check("zero_busy", int'(busy), 1);
    check("zero_cmd_ready_low", int'(cmd_ready), 0);
    drive();
    tick();
    check("zero_finish_one_cycle", int'(finish), 0);
    check("zero_back_to_idle", int'(cmd_ready), 1);
    check("zero_no_ap_start", start_seen, 0);
    check("zero_started_cnt", int'(started_cnt), 0);

    // Randomized runs.
    for (int r = 0; r < 8; r++) begin
      num = int'($urandom_range(1, 12));
      gap = int'($urandom_range(0, 15));
      issue_cmd(num, gap, -1, -1);
      wait_finish(2000);
      check("rand_started_cnt", int'(started_cnt), num);
      check("rand_done_cnt", int'(done_cnt), num);
      idle(int'($urandom_range(0, 3)));
    end

    // Spurious done while idle: sticky error, count untouched.
    idle(20);
    dc = int'(done_cnt);
    inj_done = 1'b1;
    drive();
    tick();
    check("idle_done_sets_err", int'(err_done), 1);
    check("idle_done_cnt_unchanged", int'(done_cnt), dc);
    idle(3);
    check("err_done_sticky", int'(err_done), 1);

    // Done in the same cycle as the first launch is unmatched.
    idle(20);
    issue_cmd(1, 0, 0, 3);
    check("first_push_start_pending", int'(ap_start), 1);
    inj_done = 1'b1;
    drive();
    tick();
    check("same_cycle_first_push_err", int'(err_done), 1);
    check("same_cycle_first_push_started", int'(started_cnt), 1);
    check("same_cycle_first_push_done", int'(done_cnt), 0);
    wait_finish(200);
    check("after_err_done_cnt", int'(done_cnt), 1);
    check("after_err_last_lat", int'(last_lat), 3);
    check("after_err_still_set", int'(err_done), 1);

    // Reset in the middle of a run.
    idle(2);
    issue_cmd(10, 2, 0, 8);
    idle(6);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_ap_start", int'(ap_start), 0);
    check("mid_rst_ap_continue", int'(ap_continue), 1);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_finish", int'(finish), 0);
    check("mid_rst_cmd_ready", int'(cmd_ready), 1);
    check("mid_rst_started_cnt", int'(started_cnt), 0);
    check("mid_rst_done_cnt", int'(done_cnt), 0);
    check("mid_rst_last_lat", int'(last_lat), 0);
    check("mid_rst_max_lat", int'(max_lat), 0);
    check("mid_rst_err_done", int'(err_done), 0);
    reset_model();
    idle(1);
    reset = 1'b1;
    idle(2);
    // The FIFO must have been emptied: a done now has nothing to match.
    inj_done = 1'b1;
    drive();
    tick();
    check("post_rst_fifo_empty_err", int'(err_done), 1);
    check("post_rst_done_cnt", int'(done_cnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
